// File: rtl/rsa_wrapper_pkg.sv
// Shared constants and FSM state encoding for the RSA streaming wrapper.
package rsa_wrapper_pkg;

    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;

    localparam int RX_OK_BIT = 7;
    localparam int TX_OK_BIT = 6;

    typedef enum logic [2:0] {
        Q_RX,
        RD_RX,
        START,
        WAIT,
        Q_TX,
        WR_TX
    } state_t;

endpackage

// File: rtl/rsa_avm_byte_io.sv
// Single-transaction Avalon-MM master: owns strobes and address, holds them
// through waitrequest, and reports completion in the cycle the slave accepts.
module rsa_avm_byte_io
    import rsa_wrapper_pkg::*;
(
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic        req,
    input  logic        req_write,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        done,
    output logic [7:0]  rd_byte,
    output logic        rx_ok,
    output logic        tx_ok,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest
);

    logic busy;
    logic unused_rdata_hi;

    assign busy    = avm_read | avm_write;
    assign done    = busy & ~avm_waitrequest;
    assign rd_byte = avm_readdata[7:0];
    assign rx_ok   = avm_readdata[RX_OK_BIT];
    assign tx_ok   = avm_readdata[TX_OK_BIT];
    assign unused_rdata_hi = ^avm_readdata[31:8];

    // A new request is taken when idle or in the same cycle the current one
    // completes, so polling runs back-to-back without a dead cycle.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            avm_read      <= 1'b1;
            avm_write     <= 1'b0;
            avm_address   <= STATUS_BASE;
            avm_writedata <= '0;
        end else if (!(busy && avm_waitrequest)) begin
            if (req) begin
                avm_read      <= ~req_write;
                avm_write     <= req_write;
                avm_address   <= req_addr;
                avm_writedata <= req_wdata;
            end else begin
                avm_read  <= 1'b0;
                avm_write <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rsa_stream_wrapper.sv
// Streams RSA key and ciphertext blocks from an Avalon UART into an external
// modexp core and writes the plaintext bytes back out.
//
//   state | meaning
//   Q_RX  | polling STATUS for RX_OK, inactivity timeout running
//   RD_RX | reading one byte from RX
//   START | one-cycle core_start pulse
//   WAIT  | waiting for core_finished
//   Q_TX  | polling STATUS for TX_OK
//   WR_TX | writing one plaintext byte to TX
module rsa_stream_wrapper
    import rsa_wrapper_pkg::*;
#(
    parameter int KEY_BITS       = 256,
    parameter int OUT_BYTES      = KEY_BITS/8 - 1,
    parameter int TIMEOUT_CYCLES = 32768,
    parameter int KEY_PERSIST    = 0
) (
    input  logic                avm_clk,
    input  logic                avm_rst,
    output logic [4:0]          avm_address,
    output logic                avm_read,
    input  logic [31:0]         avm_readdata,
    output logic                avm_write,
    output logic [31:0]         avm_writedata,
    input  logic                avm_waitrequest,
    output logic                core_start,
    output logic [KEY_BITS-1:0] core_a,
    output logic [KEY_BITS-1:0] core_d,
    output logic [KEY_BITS-1:0] core_n,
    input  logic [KEY_BITS-1:0] core_result,
    input  logic                core_finished,
    output logic                key_loaded,
    output logic [15:0]         block_count
);

    localparam int KEY_BYTES = KEY_BITS / 8;
    localparam int BC_W      = $clog2(2*KEY_BYTES + 1);
    localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

    state_t              state;
    logic [KEY_BITS-1:0] n_reg, d_reg, ct_reg, res_reg;
    logic [BC_W-1:0]     byte_cnt;
    logic [TO_W-1:0]     to_cnt;

    logic        io_done, io_rx_ok, io_tx_ok;
    logic [7:0]  io_byte;
    logic        req, req_write;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  tx_byte;
    logic        timeout_hit, partial_blk, blk_last, tx_last;
    logic        unused_res;

    assign core_a = ct_reg;
    assign core_d = d_reg;
    assign core_n = n_reg;

    assign timeout_hit = to_cnt >= TO_W'(TIMEOUT_CYCLES - 1);
    assign partial_blk = key_loaded && (byte_cnt != '0);
    assign blk_last    = key_loaded && (byte_cnt == BC_W'(KEY_BYTES - 1));
    assign tx_last     = byte_cnt == BC_W'(OUT_BYTES - 1);

    // Result bytes above OUT_BYTES are held but never transmitted.
    assign unused_res = ^res_reg;

    rsa_avm_byte_io u_io (
        .avm_clk         (avm_clk),
        .avm_rst         (avm_rst),
        .req             (req),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .done            (io_done),
        .rd_byte         (io_byte),
        .rx_ok           (io_rx_ok),
        .tx_ok           (io_tx_ok),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest)
    );

    always_comb begin
        tx_byte = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (byte_cnt == BC_W'(i))
                tx_byte = res_reg[8*(OUT_BYTES-1-i) +: 8];
        end
    end

    // Next bus transaction, chosen from the transition the FSM is about to take.
    always_comb begin
        req       = 1'b0;
        req_write = 1'b0;
        req_addr  = STATUS_BASE;
        req_wdata = '0;
        case (state)
            Q_RX: begin
                if (io_done && io_rx_ok) begin
                    req      = 1'b1;
                    req_addr = RX_BASE;
                end else if (!(io_done && timeout_hit && partial_blk)) begin
                    req = 1'b1;
                end
            end
            RD_RX:   req = !(io_done && blk_last);
            WAIT:    req = core_finished;
            Q_TX: begin
                req = 1'b1;
                if (io_done && io_tx_ok) begin
                    req_write = 1'b1;
                    req_addr  = TX_BASE;
                    req_wdata = {24'b0, tx_byte};
                end
            end
            WR_TX:   req = 1'b1;
            default: req = 1'b0;
        endcase
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state       <= Q_RX;
            core_start  <= 1'b0;
            key_loaded  <= 1'b0;
            block_count <= '0;
            n_reg       <= '0;
            d_reg       <= '0;
            ct_reg      <= '0;
            res_reg     <= '0;
            byte_cnt    <= '0;
            to_cnt      <= '0;
        end else begin
            core_start <= 1'b0;
            case (state)
                Q_RX: begin
                    if (io_done && io_rx_ok) begin
                        state  <= RD_RX;
                        to_cnt <= '0;
                    end else if (io_done && timeout_hit) begin
                        to_cnt <= '0;
                        if (partial_blk) begin
                            state      <= START;
                            core_start <= 1'b1;
                            byte_cnt   <= '0;
                        end else if (!key_loaded || KEY_PERSIST == 0) begin
                            n_reg      <= '0;
                            d_reg      <= '0;
                            key_loaded <= 1'b0;
                            byte_cnt   <= '0;
                        end
                    end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                RD_RX: begin
                    if (io_done) begin
                        state <= Q_RX;
                        if (!key_loaded) begin
                            if (byte_cnt < BC_W'(KEY_BYTES))
                                n_reg <= {n_reg[KEY_BITS-9:0], io_byte};
                            else
                                d_reg <= {d_reg[KEY_BITS-9:0], io_byte};
                            if (byte_cnt == BC_W'(2*KEY_BYTES - 1)) begin
                                key_loaded <= 1'b1;
                                byte_cnt   <= '0;
                            end else begin
                                byte_cnt <= byte_cnt + BC_W'(1);
                            end
                        end else begin
                            ct_reg <= {ct_reg[KEY_BITS-9:0], io_byte};
                            if (blk_last) begin
                                state      <= START;
                                core_start <= 1'b1;
                                byte_cnt   <= '0;
                            end else begin
                                byte_cnt <= byte_cnt + BC_W'(1);
                            end
                        end
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (core_finished) begin
                        res_reg <= core_result;
                        state   <= Q_TX;
                    end
                end
                Q_TX: begin
                    if (io_done && io_tx_ok)
                        state <= WR_TX;
                end
                WR_TX: begin
                    if (io_done) begin
                        if (tx_last) begin
                            state       <= Q_RX;
                            byte_cnt    <= '0;
                            block_count <= block_count + 16'd1;
                            ct_reg      <= '0;
                            to_cnt      <= '0;
                        end else begin
                            state    <= Q_TX;
                            byte_cnt <= byte_cnt + BC_W'(1);
                        end
                    end
                end
                default: state <= Q_RX;
            endcase
        end
    end

endmodule
